// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared encodings, FSM state type and taken-decision helper for branch_resolve
package branch_resolve_pkg;

    // Branch type encodings; 6 and 7 behave as NONE
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGT  = 3'd4;
    localparam logic [2:0] BR_JUMP = 3'd5;

    // Comparator result encodings
    localparam logic [1:0] CMP_EQ  = 2'd0;
    localparam logic [1:0] CMP_LT  = 2'd1;
    localparam logic [1:0] CMP_GT  = 2'd2;
    localparam logic [1:0] CMP_ILL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // An illegal compare result never makes a conditional branch taken
    function automatic logic branch_taken(input logic [2:0] br_type, input logic [1:0] res);
        logic taken;
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = (res == CMP_EQ);
            BR_BNE:  taken = (res == CMP_LT) || (res == CMP_GT);
            BR_BLT:  taken = (res == CMP_LT);
            BR_BGT:  taken = (res == CMP_GT);
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Types 1..5 are real branches for statistics purposes
    function automatic logic is_branch(input logic [2:0] br_type);
        return (br_type != BR_NONE) && (br_type <= BR_JUMP);
    endfunction

endpackage

// File: rtl/branch_target_add.sv
// rtl/branch_target_add.sv - combinational 32-bit branch target adder (wraps modulo 2^32)
module branch_target_add (
    input  logic [31:0] pc_plus1,
    input  logic [31:0] imm,
    output logic [31:0] target
);

    assign target = pc_plus1 + imm;

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch resolution FSM issuing redirect and flush; optional stats via BRANCH_RESOLVE_STATS_EN
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int RSV_ENC_ERR  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        comp_valid,
    input  logic [1:0]  comp_result,
    input  logic [2:0]  br_type,
    input  logic [31:0] pc_plus1,
    input  logic [31:0] imm,
    input  logic        stall,
    output logic        ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        enc_err
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] not_taken_cnt
`endif
);

    // FLUSH state lasts FLUSH_CYCLES-1 cycles; zero means REDIRECT returns straight to IDLE
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        enc_err_q, enc_err_d;

    logic        accept;
    logic        taken;
    logic [31:0] target;

    branch_target_add u_target_add (
        .pc_plus1 (pc_plus1),
        .imm      (imm),
        .target   (target)
    );

    assign accept = comp_valid && ready_q;
    assign taken  = branch_taken(br_type, comp_result);

    // Next-state and next-output decode for the redirect/flush sequence
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        ready_d          = ready_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        enc_err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    enc_err_d = (RSV_ENC_ERR == 1) && (comp_result == CMP_ILL);
                    if (taken) begin
                        state_d          = ST_REDIRECT;
                        redirect_pc_d    = target;
                        redirect_valid_d = 1'b1;
                        flush_d          = 1'b1;
                        ready_d          = 1'b0;
                    end
                end
            end
            ST_REDIRECT: begin
                if (!stall) begin
                    redirect_valid_d = 1'b0;
                    if (FLUSH_LOAD == 3'd0) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    flush_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                cnt_d            = 3'd0;
                ready_d          = 1'b1;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any redirect in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 3'd0;
            ready_q          <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            flush_q          <= 1'b0;
            enc_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ready_q          <= ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            enc_err_q        <= enc_err_d;
        end
    end

    assign ready          = ready_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign enc_err        = enc_err_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] not_taken_cnt_q, not_taken_cnt_d;

    // Saturating counts of accepted real branches, split by outcome
    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (accept && is_branch(br_type)) begin
            if (taken) begin
                if (taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_d = taken_cnt_q + 32'd1;
            end else begin
                if (not_taken_cnt_q != 32'hFFFF_FFFF) not_taken_cnt_d = not_taken_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            taken_cnt_q     <= 32'h0;
            not_taken_cnt_q <= 32'h0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`else
    // Statistics counters are not built in this configuration
`endif

endmodule
